aes_cbc_pkcs7_pad: RTL and testbench

AES_CBC_PKCS7_PAD -- requirements
Module: aes_cbc_pkcs7_pad

---
 rtl/aes_cbc_pkcs7_pad_if.sv | 13 +
 rtl/aes_cbc_pkcs7_pad.sv | 147 ++++++++++++++
 tb/tb_aes_cbc_pkcs7_pad.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_cbc_pkcs7_pad_if.sv
// Byte-wide AXI-Stream bundle shared by the upstream frame source and the AES core side.
// The slave view has no tkeep because every input beat carries exactly one valid byte.
interface axis_if;
  logic       tvalid;
  logic       tready;
  logic [7:0] tdata;
  logic       tuser;
  logic       tlast;
  logic       tkeep;

  modport master (output tvalid, tdata, tuser, tlast, tkeep, input tready);
  modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/aes_cbc_pkcs7_pad.sv
// Framing front-end for an AES-256-CBC core: passes key/IV/payload through with zero latency
// and, for encrypt frames, appends PKCS#7 padding bytes after the last payload byte.
module aes_cbc_pkcs7_pad (
  input  logic    Clk,
  input  logic    Rst_n,
  axis_if.slave   S_axis,
  axis_if.master  M_axis,
  output logic    Frame_err
);

  typedef enum logic [1:0] {ST_HEADER, ST_PAYLOAD, ST_PAD} state_e;

  localparam logic [5:0] HDR_LAST = 6'd47;

  state_e     state_q, state_d;
  logic [5:0] hdr_cnt_q, hdr_cnt_d;
  logic [3:0] blk_cnt_q, blk_cnt_d;
  logic [4:0] pad_cnt_q, pad_cnt_d;
  logic [4:0] pad_val_q, pad_val_d;
  logic       enc_q, enc_d;
  logic       err_q, err_d;

  logic       s_beat;
  logic       m_beat;
  logic       enc_now;
  logic       hdr_last;
  logic [3:0] blk_inc;
  logic [4:0] pad_len;

  assign s_beat   = S_axis.tvalid && S_axis.tready;
  assign m_beat   = M_axis.tvalid && M_axis.tready;
  // The direction bit is only latched on header byte 0, so use the live value on that beat.
  assign enc_now  = (hdr_cnt_q == 6'd0) ? S_axis.tuser : enc_q;
  assign hdr_last = (hdr_cnt_q == HDR_LAST);
  assign blk_inc  = blk_cnt_q + 4'd1;
  // A completed block (blk_inc wrapped to 0) yields 16 naturally from the subtraction.
  assign pad_len  = 5'd16 - {1'b0, blk_inc};

  assign M_axis.tkeep = 1'b1;
  assign Frame_err    = err_q;

  // Datapath / handshake muxing; all outputs are forced quiet while reset is held.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    M_axis.tvalid = 1'b0;
    M_axis.tdata  = 8'h00;
    M_axis.tuser  = 1'b0;
    M_axis.tlast  = 1'b0;
    S_axis.tready = 1'b0;
    if (Rst_n) begin
      unique case (state_q)
        ST_HEADER: begin
          M_axis.tvalid = S_axis.tvalid;
          S_axis.tready = M_axis.tready;
          M_axis.tdata  = S_axis.tdata;
          M_axis.tuser  = enc_now;
          M_axis.tlast  = S_axis.tlast && !(hdr_last && enc_now);
        end
        ST_PAYLOAD: begin
          M_axis.tvalid = S_axis.tvalid;
          S_axis.tready = M_axis.tready;
          M_axis.tdata  = S_axis.tdata;
          M_axis.tuser  = enc_q;
          M_axis.tlast  = S_axis.tlast && !enc_q;
        end
        ST_PAD: begin
          M_axis.tvalid = 1'b1;
          M_axis.tdata  = {3'b000, pad_val_q};
          M_axis.tuser  = enc_q;
          M_axis.tlast  = (pad_cnt_q == 5'd1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    blk_cnt_d = blk_cnt_q;
    pad_cnt_d = pad_cnt_q;
    pad_val_d = pad_val_q;
    enc_d     = enc_q;
    err_d     = 1'b0;
    unique case (state_q)
      ST_HEADER: if (s_beat) begin
        if (hdr_cnt_q == 6'd0) enc_d = S_axis.tuser;
        if (S_axis.tlast) begin
          hdr_cnt_d = 6'd0;
          if (hdr_last && enc_now) begin
            pad_val_d = 5'd16;
            pad_cnt_d = 5'd16;
            state_d   = ST_PAD;
          end else begin
            err_d = 1'b1;
          end
        end else if (hdr_last) begin
          hdr_cnt_d = 6'd0;
          blk_cnt_d = 4'd0;
          state_d   = ST_PAYLOAD;
        end else begin
          hdr_cnt_d = hdr_cnt_q + 6'd1;
        end
      end
      ST_PAYLOAD: if (s_beat) begin
        blk_cnt_d = blk_inc;
        if (S_axis.tlast) begin
          if (enc_q) begin
            pad_val_d = pad_len;
            pad_cnt_d = pad_len;
            state_d   = ST_PAD;
          end else begin
            err_d   = (blk_inc != 4'd0);
            state_d = ST_HEADER;
          end
        end
      end
      ST_PAD: if (m_beat) begin
        pad_cnt_d = pad_cnt_q - 5'd1;
        if (pad_cnt_q == 5'd1) state_d = ST_HEADER;
      end
      default: state_d = ST_HEADER;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= ST_HEADER;
      hdr_cnt_q <= 6'd0;
      blk_cnt_q <= 4'd0;
      pad_cnt_q <= 5'd0;
      pad_val_q <= 5'd0;
      enc_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      blk_cnt_q <= blk_cnt_d;
      pad_cnt_q <= pad_cnt_d;
      pad_val_q <= pad_val_d;
      enc_q     <= enc_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_aes_cbc_pkcs7_pad.sv
// Bench for aes_cbc_pkcs7_pad: table of frames driven through a scoreboard of expected
// output beats, plus a hand-written reset-during-padding sequence.
module tb_aes_cbc_pkcs7_pad;

  logic clk = 1'b0;
  logic rst_n;
  logic frame_err;
  logic rdy_q = 1'b1;
  logic hold;
  int   rdy_mode;

  always #5 clk = ~clk;

  axis_if s_if ();
  axis_if m_if ();

  aes_cbc_pkcs7_pad dut (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .S_axis    (s_if),
    .M_axis    (m_if),
    .Frame_err (frame_err)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       user;
    logic       last;
  } beat_t;

  typedef struct {
    bit         enc;
    int         hdr_len;
    int         len;
    int         rdy;
    int         exp_beats;
    logic [7:0] pad_val;
    int         pad_n;
    int         exp_err;
  } vec_t;

  beat_t      sb[$];
  beat_t      exp_b;
  int         n_pass;
  int         n_total;
  int         beats_seen;
  int         errs_seen;
  logic       stall_prev;
  logic [7:0] stall_data;
  logic       err_prev;
  vec_t       vecs[12];

  // Downstream ready pattern: 0 always, 1 toggling, 2 random, other = low.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       rdy_q = 1'b1;
      1:       rdy_q = ~rdy_q;
      2:       rdy_q = 1'($urandom_range(0, 1));
      default: rdy_q = 1'b0;
    endcase
  end
  assign m_if.tready = rdy_q && !hold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_if.tvalid && m_if.tready) begin
        beats_seen++;
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_beat: got data 0x%0h, expected no beat (t=%0t)", m_if.tdata, $time);
        end else begin
          exp_b = sb.pop_front();
          check("out_tdata", 32'(m_if.tdata), 32'(exp_b.data));
          check("out_tuser", 32'(m_if.tuser), 32'(exp_b.user));
          check("out_tlast", 32'(m_if.tlast), 32'(exp_b.last));
          check("out_tkeep", 32'(m_if.tkeep), 32'd1);
        end
      end
      if (stall_prev) begin
        check("stall_tvalid", 32'(m_if.tvalid), 32'd1);
        check("stall_tdata", 32'(m_if.tdata), 32'(stall_data));
      end
      stall_prev = m_if.tvalid && !m_if.tready;
      stall_data = m_if.tdata;
      if (frame_err) begin
        errs_seen++;
        check("frame_err_width", 32'(err_prev), 32'd0);
      end
      err_prev = frame_err;
    end else begin
      stall_prev = 1'b0;
      err_prev   = 1'b0;
    end
  end

  task automatic drive_beat(input logic [7:0] d, input logic u, input logic l, output bit ok);
    bit hs;
    ok = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tuser  = u;
    s_if.tlast  = l;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      hs = s_if.tready;
      @(posedge clk);
      #1;
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_frame(input vec_t v);
    int   n_in;
    bit   ok;
    bit   pads;
    logic [7:0] d;
    logic l;
    n_in = v.hdr_len + v.len;
    pads = v.enc && (v.hdr_len == 48);
    for (int i = 0; i < n_in; i++) begin
      d = 8'($urandom);
      l = (i == n_in - 1);
      sb.push_back('{data: d, user: v.enc, last: l && !pads});
      if (l && pads)
        for (int p = 0; p < v.pad_n; p++)
          sb.push_back('{data: v.pad_val, user: v.enc, last: (p == v.pad_n - 1)});
      drive_beat(d, (i == 0) ? v.enc : !v.enc, l, ok);
      if (!ok) begin
        check("s_handshake", 32'(ok), 32'd1);
        break;
      end
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int b0;
    int e0;
    int t;
    b0 = beats_seen;
    e0 = errs_seen;
    t  = 0;
    rdy_mode = v.rdy;
    send_frame(v);
    while (sb.size() != 0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    check({name, "_drain"}, 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    check({name, "_beats"}, 32'(beats_seen - b0), 32'(v.exp_beats));
    check({name, "_frame_err"}, 32'(errs_seen - e0), 32'(v.exp_err));
    rdy_mode = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int b0;
    n_pass     = 0;
    n_total    = 0;
    beats_seen = 0;
    errs_seen  = 0;
    stall_prev = 1'b0;
    err_prev   = 1'b0;
    stall_data = 8'h00;
    hold       = 1'b0;
    rdy_mode   = 0;
    rst_n      = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = 8'hA5;
    s_if.tuser  = 1'b1;
    s_if.tlast  = 1'b1;
    s_if.tkeep  = 1'b1;

    //          enc  hdr  len rdy beats pad    n   err
    vecs[0]  = '{1'b1, 48,  5, 0,  64, 8'h0B, 11, 0};
    vecs[1]  = '{1'b1, 48, 32, 0,  96, 8'h10, 16, 0};
    vecs[2]  = '{1'b1, 48,  0, 0,  64, 8'h10, 16, 0};
    vecs[3]  = '{1'b0, 48, 16, 0,  64, 8'h00,  0, 0};
    vecs[4]  = '{1'b0, 48, 17, 0,  65, 8'h00,  0, 1};
    vecs[5]  = '{1'b1, 48, 15, 1,  64, 8'h01,  1, 0};
    vecs[6]  = '{1'b0, 48,  0, 0,  48, 8'h00,  0, 1};
    vecs[7]  = '{1'b0, 20,  0, 0,  20, 8'h00,  0, 1};
    vecs[8]  = '{1'b1, 10,  0, 2,  10, 8'h00,  0, 1};
    vecs[9]  = '{1'b1, 48, 16, 2,  80, 8'h10, 16, 0};
    vecs[10] = '{1'b0, 48, 33, 2,  81, 8'h00,  0, 1};
    vecs[11] = '{1'b1, 48, 31, 1,  80, 8'h01,  1, 0};

    // Outputs must be quiet while reset is held, even with live upstream traffic.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check("rst_m_tdata", 32'(m_if.tdata), 32'd0);
    check("rst_m_tlast", 32'(m_if.tlast), 32'd0);
    check("rst_s_tready", 32'(s_if.tready), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset pulsed while the single pad byte of an L=15 encrypt frame is stalled.
    rdy_mode = 0;
    send_frame('{1'b1, 48, 15, 0, 64, 8'h01, 1, 0});
    #1;
    hold = 1'b1;
    repeat (3) @(negedge clk);
    check("pad_pending", 32'(sb.size()), 32'd1);
    check("pad_hold_tvalid", 32'(m_if.tvalid), 32'd1);
    check("pad_hold_tdata", 32'(m_if.tdata), 32'h01);
    check("pad_hold_tlast", 32'(m_if.tlast), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check("midrst_m_tdata", 32'(m_if.tdata), 32'd0);
    check("midrst_s_tready", 32'(s_if.tready), 32'd0);
    sb.delete();
    b0 = beats_seen;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hold  = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("post_rst_no_stray_beats", 32'(beats_seen - b0), 32'd0);
    check("post_rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    run_vec(vecs[0], "post_rst_enc_l5");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
